// File: rtl/lcd_bus_writer_if.sv
// FIFO read-side handshake between the LCD command FIFO and the bus writer.
// Words are {rs, data[7:0]}.
interface lcd_bus_writer_if;
    logic       in_valid;
    logic       in_ready;
    logic [8:0] in_data;

    modport master (output in_valid, output in_data, input in_ready);
    modport slave  (input in_valid, input in_data, output in_ready);
endinterface

// File: rtl/lcd_bus_writer.sv
// HD44780 8-bit write sequencer: pops {rs, data} words and drives setup,
// E pulse, hold and execution wait, including the power-up delay.
//
// state | meaning
// INIT  | power-up wait after reset, nothing accepted
// IDLE  | in_ready high, waiting for a word
// SETUP | RS/D driven, E low
// PULSE | E high
// HOLD  | E low, RS/D held
// WAIT  | execution time of the written command/data
module lcd_bus_writer #(
    parameter int SETUP_CYCLES     = 2,
    parameter int PULSE_CYCLES     = 13,
    parameter int HOLD_CYCLES      = 2,
    parameter int EXEC_CYCLES      = 1100,
    parameter int LONG_EXEC_CYCLES = 44000,
    parameter int POWERUP_CYCLES   = 1080000
) (
    input  logic             clk,
    input  logic             rst,
    lcd_bus_writer_if.slave  fifo,
    output logic             lcd_rs,
    output logic             lcd_rw,
    output logic             lcd_e,
    output logic [7:0]       lcd_d,
    output logic             busy
);

    localparam int MAX_A = (SETUP_CYCLES > PULSE_CYCLES) ? SETUP_CYCLES : PULSE_CYCLES;
    localparam int MAX_B = (HOLD_CYCLES > EXEC_CYCLES) ? HOLD_CYCLES : EXEC_CYCLES;
    localparam int MAX_C = (LONG_EXEC_CYCLES > POWERUP_CYCLES) ? LONG_EXEC_CYCLES : POWERUP_CYCLES;
    localparam int MAX_AB = (MAX_A > MAX_B) ? MAX_A : MAX_B;
    localparam int MAX_ALL = (MAX_AB > MAX_C) ? MAX_AB : MAX_C;
    localparam int CW = $clog2(MAX_ALL + 1);

    // Each state lasts N cycles: load N-1 on entry, leave when the count hits 0.
    localparam logic [CW-1:0] LD_SETUP   = CW'(SETUP_CYCLES - 1);
    localparam logic [CW-1:0] LD_PULSE   = CW'(PULSE_CYCLES - 1);
    localparam logic [CW-1:0] LD_HOLD    = CW'(HOLD_CYCLES - 1);
    localparam logic [CW-1:0] LD_EXEC    = CW'(EXEC_CYCLES - 1);
    localparam logic [CW-1:0] LD_LONG    = CW'(LONG_EXEC_CYCLES - 1);
    localparam logic [CW-1:0] LD_POWERUP = CW'(POWERUP_CYCLES - 1);

    typedef enum logic [2:0] {
        INIT  = 3'd0,
        IDLE  = 3'd1,
        SETUP = 3'd2,
        PULSE = 3'd3,
        HOLD  = 3'd4,
        WAIT  = 3'd5
    } state_t;

    state_t        state, state_next;
    logic [CW-1:0] cnt, cnt_next;
    logic          accept;
    logic          long_wait;
    logic          cnt_zero;

    assign cnt_zero      = (cnt == '0);
    assign fifo.in_ready = (state == IDLE);
    assign busy          = (state != IDLE);
    assign lcd_rw        = 1'b0;

    always_comb begin
        state_next = state;
        cnt_next   = cnt_zero ? '0 : cnt - CW'(1);
        accept     = 1'b0;
        case (state)
            INIT: begin
                if (cnt_zero) state_next = IDLE;
            end
            IDLE: begin
                cnt_next = '0;
                if (fifo.in_valid) begin
                    accept     = 1'b1;
                    state_next = SETUP;
                    cnt_next   = LD_SETUP;
                end
            end
            SETUP: begin
                if (cnt_zero) begin
                    state_next = PULSE;
                    cnt_next   = LD_PULSE;
                end
            end
            PULSE: begin
                if (cnt_zero) begin
                    state_next = HOLD;
                    cnt_next   = LD_HOLD;
                end
            end
            HOLD: begin
                if (cnt_zero) begin
                    state_next = WAIT;
                    cnt_next   = long_wait ? LD_LONG : LD_EXEC;
                end
            end
            WAIT: begin
                if (cnt_zero) state_next = IDLE;
            end
            default: begin
                state_next = INIT;
                cnt_next   = LD_POWERUP;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= INIT;
            cnt       <= LD_POWERUP;
            lcd_e     <= 1'b0;
            lcd_rs    <= 1'b0;
            lcd_d     <= 8'h00;
            long_wait <= 1'b0;
        end else begin
            state <= state_next;
            cnt   <= cnt_next;
            lcd_e <= (state_next == PULSE);
            if (accept) begin
                lcd_rs    <= fifo.in_data[8];
                lcd_d     <= fifo.in_data[7:0];
                // clear (0x01) and return-home (0x02/0x03) need the long wait
                long_wait <= ~fifo.in_data[8] && (fifo.in_data[7:2] == 6'd0)
                             && (fifo.in_data[1:0] != 2'd0);
            end
        end
    end

endmodule

// File: tb/tb_lcd_bus_writer.sv
// Bench for lcd_bus_writer: timeline reference model checked every cycle,
// plus table-driven write periods, streaming, mid-pulse reset and random traffic.
module tb_lcd_bus_writer;

    localparam int S       = 2;
    localparam int P       = 3;
    localparam int H       = 2;
    localparam int EXEC    = 5;
    localparam int LONG    = 20;
    localparam int POWERUP = 10;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       lcd_rs, lcd_rw, lcd_e, busy;
    logic [7:0] lcd_d;

    lcd_bus_writer_if fifo();

    lcd_bus_writer #(
        .SETUP_CYCLES(S), .PULSE_CYCLES(P), .HOLD_CYCLES(H),
        .EXEC_CYCLES(EXEC), .LONG_EXEC_CYCLES(LONG), .POWERUP_CYCLES(POWERUP)
    ) dut (
        .clk(clk), .rst(rst), .fifo(fifo),
        .lcd_rs(lcd_rs), .lcd_rw(lcd_rw), .lcd_e(lcd_e), .lcd_d(lcd_d), .busy(busy)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Timeline model: cycle numbers count from reset release.
    int         cyc;
    int         free_at, e_from, e_to, bus_from;
    logic [8:0] prev_w, new_w;
    logic       prev_e;
    logic       dut_acc;
    int         acc_cyc;
    int         e_rises;
    logic [8:0] e_words[$];

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s cyc=%0d got=%0h expected=%0h", name, cyc, act, exp);
        end
    endtask

    function automatic bit is_long(input logic [8:0] w);
        return (w[8] == 1'b0) && (w[7:0] >= 8'd1) && (w[7:0] <= 8'd3);
    endfunction

    task automatic model_reset();
        cyc      = 0;
        free_at  = POWERUP;
        e_from   = 1;
        e_to     = 0;
        bus_from = 0;
        prev_w   = 9'h000;
        new_w    = 9'h000;
        prev_e   = 1'b0;
    endtask

    // Called at a negedge: drive inputs, check this cycle, advance model.
    task automatic step(input logic v, input logic [8:0] d);
        logic [8:0] cur;
        logic       m_ready;
        fifo.in_valid = v;
        fifo.in_data  = d;
        m_ready = (cyc >= free_at);
        cur     = (cyc >= bus_from) ? new_w : prev_w;
        chk("in_ready", int'(fifo.in_ready), int'(m_ready));
        chk("busy", int'(busy), int'(!m_ready));
        chk("lcd_e", int'(lcd_e), int'(cyc >= e_from && cyc <= e_to));
        chk("lcd_rs", int'(lcd_rs), int'(cur[8]));
        chk("lcd_d", int'(lcd_d), int'(cur[7:0]));
        chk("lcd_rw", int'(lcd_rw), 0);
        if (lcd_e && !prev_e) begin
            e_rises++;
            e_words.push_back({lcd_rs, lcd_d});
        end
        prev_e  = lcd_e;
        dut_acc = fifo.in_ready && v;
        if (dut_acc) acc_cyc = cyc;
        if (m_ready && v) begin
            prev_w   = cur;
            new_w    = d;
            bus_from = cyc + 1;
            e_from   = cyc + 1 + S;
            e_to     = cyc + S + P;
            free_at  = cyc + 1 + S + P + H + (is_long(d) ? LONG : EXEC);
        end
        cyc++;
        @(negedge clk);
    endtask

    task automatic wait_idle(input int budget);
        int n = 0;
        while (!fifo.in_ready && n < budget) begin
            step(1'b0, 9'($urandom));
            n++;
        end
        if (!fifo.in_ready) chk("idle_timeout", 0, 1);
    endtask

    task automatic send(input logic [8:0] w, input int period, input string name);
        int a;
        int n = 0;
        wait_idle(100);
        a = cyc;
        step(1'b1, w);
        while (!fifo.in_ready && n < 100) begin
            step(1'b0, 9'($urandom));
            n++;
        end
        chk(name, cyc - a, period);
    endtask

    task automatic reset_checks(input string tag);
        chk({tag, "_ready"}, int'(fifo.in_ready), 0);
        chk({tag, "_busy"}, int'(busy), 1);
        chk({tag, "_e"}, int'(lcd_e), 0);
        chk({tag, "_rs"}, int'(lcd_rs), 0);
        chk({tag, "_d"}, int'(lcd_d), 0);
        chk({tag, "_rw"}, int'(lcd_rw), 0);
    endtask

    typedef struct {
        logic [8:0] word;
        int         period;
    } vec_t;

    vec_t       tbl[7];
    logic [8:0] stream[4];
    int         accs[4];

    initial begin
        int         idx, n;
        bit         got;
        logic       v;
        logic [8:0] d;

        tbl[0] = '{9'h141, 13};
        tbl[1] = '{9'h001, 28};
        tbl[2] = '{9'h003, 28};
        tbl[3] = '{9'h000, 13};
        tbl[4] = '{9'h101, 13};
        tbl[5] = '{9'h002, 28};
        tbl[6] = '{9'h004, 13};
        stream[0] = 9'h148;
        stream[1] = 9'h065;
        stream[2] = 9'h16C;
        stream[3] = 9'h080;

        // Power-up with a word already pending
        fifo.in_valid = 1'b1;
        fifo.in_data  = 9'h130;
        repeat (3) @(negedge clk);
        cyc = 0;
        reset_checks("reset");
        rst = 1'b0;
        model_reset();
        got = 1'b0;
        for (int i = 0; i < 40 && !got; i++) begin
            step(1'b1, 9'h130);
            if (dut_acc) got = 1'b1;
        end
        chk("first_accept", got ? acc_cyc : -1, POWERUP);

        // Table of single writes with their expected accept-to-ready periods
        for (int i = 0; i < 7; i++) send(tbl[i].word, tbl[i].period, "period");

        // Stream of four words with in_valid held high
        wait_idle(100);
        e_rises = 0;
        e_words.delete();
        idx = 0;
        n   = 0;
        while ((idx < 4 || !fifo.in_ready) && n < 200) begin
            step(idx < 4, stream[idx & 3]);
            if (dut_acc && idx < 4) begin
                accs[idx] = acc_cyc;
                idx++;
            end
            n++;
        end
        chk("stream_accepts", idx, 4);
        for (int i = 1; i < 4; i++) chk("stream_spacing", accs[i] - accs[i-1], 13);
        chk("stream_pulses", e_rises, 4);
        chk("stream_words", e_words.size(), 4);
        for (int i = 0; i < 4 && i < e_words.size(); i++)
            chk("stream_order", int'(e_words[i]), int'(stream[i]));

        // Reset while E is high
        wait_idle(100);
        step(1'b1, 9'h155);
        n = 0;
        while (!lcd_e && n < 20) begin
            step(1'b0, 9'h000);
            n++;
        end
        chk("reached_pulse", int'(lcd_e), 1);
        #1 rst = 1'b1;
        #1 reset_checks("async_rst");
        @(negedge clk);
        @(negedge clk);
        reset_checks("held_rst");
        rst = 1'b0;
        model_reset();
        e_rises = 0;
        for (int i = 0; i < 30; i++) step(1'b0, 9'h155);
        chk("no_resend", e_rises, 0);

        // Random traffic, in_valid toggling in every state
        for (int i = 0; i < 400; i++) begin
            v = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 3) == 0) d = 9'($urandom_range(1, 3));
            else d = 9'($urandom);
            step(v, d);
        end
        wait_idle(100);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
